// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings and datapath width
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100
    } alu_op_e;

    localparam logic [2:0] ALU_OP_MAX = 3'b100;

endpackage

// File: rtl/alu_basic.sv
// rtl/alu_basic.sv - basic 32-bit ALU: ADD/SUB/AND/OR/XOR, illegal selects flag err
module alu_basic
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] result,
    output logic            err
);

    always_comb begin
        result = '0;
        err    = (sel > ALU_OP_MAX);
        case (alu_op_e'(sel))
            ALU_ADD: result = src1 + src2;
            ALU_SUB: result = src1 + ~src2 + XLEN'(1);
            ALU_AND: result = src1 & src2;
            ALU_OR:  result = src1 | src2;
            ALU_XOR: result = src1 ^ src2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter scanning upward from rr_ptr
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            logic [ID_W-1:0] idx;
            // Wrap manually so non-power-of-two NUM_REQ stays in range.
            k = int'(rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            idx = ID_W'(k);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one ALU shared round-robin by NUM_REQ requesters, one-entry tagged response slot
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_src1,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_src2,
    input  logic [NUM_REQ-1:0][2:0]        req_sel,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [XLEN-1:0]                rsp_result,
    output logic                           rsp_err
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    rr_ptr;
    logic               can_accept;
    logic               issue;
    logic [XLEN-1:0]    alu_result;
    logic               alu_err;

    // Slot refills in the same cycle it drains, giving one op per cycle.
    assign can_accept = !rsp_valid || rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .en      (can_accept),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign issue     = |(req_valid & gnt);

    alu_basic u_alu (
        .src1   (req_src1[gnt_idx]),
        .src2   (req_src2[gnt_idx]),
        .sel    (req_sel[gnt_idx]),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rr_ptr     <= '0;
        end else if (issue) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_idx;
            rsp_result <= alu_result;
            rsp_err    <= alu_err;
            rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule
